// File: rtl/analog_pkg.sv
// Shared definitions for the analog delay bank: lane FSM states and mode encodings.
package analog_pkg;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_RISE_WAIT = 2'd1,
    ST_HIGH      = 2'd2,
    ST_FALL_WAIT = 2'd3
  } lane_state_t;

  localparam logic MODE_LATCH  = 1'b0;
  localparam logic MODE_FOLLOW = 1'b1;

endpackage

// File: rtl/delay_lane.sv
// Single delay lane: input edge detect, rise/fall delay down-counter and lane FSM.
//   state      | meaning
//   LOW        | output low, idle
//   RISE_WAIT  | rise seen, counting rise delay, output still low
//   HIGH       | output high
//   FALL_WAIT  | fall seen (FOLLOW only), counting fall delay, output still high
module delay_lane
  import analog_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_sig,
  input  logic             clr,
  input  logic             mode,
  input  logic [CNT_W-1:0] rise_dly,
  input  logic [CNT_W-1:0] fall_dly,
  output logic             out_sig,
  output logic             busy
);

  lane_state_t      r_state;
  lane_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_prev;
  logic             r_out;

  logic             w_rise;
  logic             w_fall;
  logic             w_follow;
  logic             w_tc;
  logic [CNT_W-1:0] w_cnt_dec;

  assign w_rise    = in_sig & ~r_prev;
  assign w_fall    = ~in_sig & r_prev;
  assign w_follow  = (mode == MODE_FOLLOW);
  assign w_tc      = (r_cnt == CNT_W'(1));
  assign w_cnt_dec = (r_cnt != '0) ? (r_cnt - CNT_W'(1)) : '0;

  // prev_in always tracks in_sig, including on clr, so a level held through clr cannot retrigger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_LOW;
      r_cnt   <= '0;
      r_prev  <= 1'b0;
      r_out   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_prev  <= in_sig;
      r_out   <= (w_state_nxt == ST_HIGH) || (w_state_nxt == ST_FALL_WAIT);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (clr) begin
      w_state_nxt = ST_LOW;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        ST_LOW: begin
          if (w_rise) begin
            if (rise_dly == '0) begin
              w_state_nxt = ST_HIGH;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = ST_RISE_WAIT;
              w_cnt_nxt   = rise_dly;
            end
          end
        end
        ST_RISE_WAIT: begin
          if (w_follow && w_fall) begin
            w_state_nxt = ST_LOW;
            w_cnt_nxt   = '0;
          end else if (w_tc) begin
            w_state_nxt = ST_HIGH;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_dec;
          end
        end
        ST_HIGH: begin
          if (w_follow && w_fall) begin
            if (fall_dly == '0) begin
              w_state_nxt = ST_LOW;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = ST_FALL_WAIT;
              w_cnt_nxt   = fall_dly;
            end
          end
        end
        ST_FALL_WAIT: begin
          // Dropping to LATCH mid-fall, or a re-rise, keeps the output high.
          if (!w_follow || w_rise) begin
            w_state_nxt = ST_HIGH;
            w_cnt_nxt   = '0;
          end else if (w_tc) begin
            w_state_nxt = ST_LOW;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_dec;
          end
        end
        default: begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    busy = (r_state == ST_RISE_WAIT) || (r_state == ST_FALL_WAIT);
  end

  assign out_sig = r_out;

endmodule

// File: rtl/analog_delay_bank.sv
// Bank of LANES independent inertial/latching delay lanes sharing mode and delay settings.
module analog_delay_bank
  import analog_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LANES-1:0] in_sig,
  input  logic [LANES-1:0] clr,
  input  logic             mode,
  input  logic [CNT_W-1:0] rise_dly,
  input  logic [CNT_W-1:0] fall_dly,
  output logic [LANES-1:0] out_sig,
  output logic [LANES-1:0] busy
);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    delay_lane #(
      .CNT_W(CNT_W)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_sig  (in_sig[g]),
      .clr     (clr[g]),
      .mode    (mode),
      .rise_dly(rise_dly),
      .fall_dly(fall_dly),
      .out_sig (out_sig[g]),
      .busy    (busy[g])
    );
  end

endmodule

// File: tb/tb_analog_delay_bank.sv
// Scoreboard bench for analog_delay_bank: directed scenarios plus random traffic vs. a timestamp model.
module tb_analog_delay_bank;

  localparam int LANES = 4;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic [LANES-1:0] in_sig;
  logic [LANES-1:0] clr;
  logic             mode;
  logic [CNT_W-1:0] rise_dly;
  logic [CNT_W-1:0] fall_dly;
  logic [LANES-1:0] out_sig;
  logic [LANES-1:0] busy;

  analog_delay_bank #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_sig  (in_sig),
    .clr     (clr),
    .mode    (mode),
    .rise_dly(rise_dly),
    .fall_dly(fall_dly),
    .out_sig (out_sig),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [LANES-1:0] out;
    logic [LANES-1:0] busy;
    int               n;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_edge   = 0;
  bit   started  = 1'b0;

  // Stimulus for the next edge
  logic [LANES-1:0] g_in   = '0;
  logic [LANES-1:0] g_clr  = '0;
  logic             g_mode = 1'b0;
  logic [CNT_W-1:0] g_rd   = '0;
  logic [CNT_W-1:0] g_fd   = '0;
  logic             g_rst  = 1'b0;

  // Reference model: output level plus a pending change (0 none, 1 rise, 2 fall) due at an absolute edge
  bit m_out [LANES];
  bit m_prev[LANES];
  int m_pend[LANES];
  int m_when[LANES];

  task automatic check(input string name, input logic [LANES-1:0] act, input logic [LANES-1:0] exp, input int n);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s edge=%0d actual=%b expected=%b", name, n, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int l = 0; l < LANES; l++) begin
      m_out[l]  = 1'b0;
      m_prev[l] = 1'b0;
      m_pend[l] = 0;
      m_when[l] = 0;
    end
  endfunction

  function automatic void model_edge();
    for (int l = 0; l < LANES; l++) begin
      bit in_b, rise, fall, follow;
      in_b   = g_in[l];
      rise   = in_b && !m_prev[l];
      fall   = !in_b && m_prev[l];
      follow = g_mode;
      if (g_clr[l]) begin
        m_out[l]  = 1'b0;
        m_pend[l] = 0;
      end else if (m_pend[l] == 1) begin
        if (follow && fall) m_pend[l] = 0;
        else if (n_edge == m_when[l]) begin
          m_out[l]  = 1'b1;
          m_pend[l] = 0;
        end
      end else if (m_pend[l] == 2) begin
        if (!follow || rise) m_pend[l] = 0;
        else if (n_edge == m_when[l]) begin
          m_out[l]  = 1'b0;
          m_pend[l] = 0;
        end
      end else if (!m_out[l] && rise) begin
        if (g_rd == 0) m_out[l] = 1'b1;
        else begin
          m_pend[l] = 1;
          m_when[l] = n_edge + int'(g_rd);
        end
      end else if (m_out[l] && follow && fall) begin
        if (g_fd == 0) m_out[l] = 1'b0;
        else begin
          m_pend[l] = 2;
          m_when[l] = n_edge + int'(g_fd);
        end
      end
      m_prev[l] = in_b;
    end
  endfunction

  task automatic step();
    exp_t e;
    @(negedge clk);
    in_sig   = g_in;
    clr      = g_clr;
    mode     = g_mode;
    rise_dly = g_rd;
    fall_dly = g_fd;
    rst_n    = g_rst;
    n_edge++;
    if (!g_rst) begin
      #1;
      check("rst_out_immediate", out_sig, '0, n_edge);
      check("rst_busy_immediate", busy, '0, n_edge);
      model_reset();
    end else begin
      model_edge();
    end
    for (int l = 0; l < LANES; l++) begin
      e.out[l]  = m_out[l];
      e.busy[l] = (m_pend[l] != 0);
    end
    e.n = n_edge;
    q.push_back(e);
    started = 1'b1;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  // Monitor: outputs are presented every edge; compare them against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (started) begin
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL scoreboard_empty actual=0 entries required=1");
        end else begin
          e = q.pop_front();
          check("out_sig", out_sig, e.out, e.n);
          check("busy", busy, e.busy, e.n);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int rst_hold;
    in_sig = '0; clr = '0; mode = 1'b0; rise_dly = '0; fall_dly = '0; rst_n = 1'b0;
    model_reset();

    // Reset state
    g_rst = 1'b0;
    run(3);

    // Latch mode, long rise delay, input drops during the count
    g_rst = 1'b1; g_mode = 1'b0; g_rd = 16'd1000;
    run(10);
    g_in[0] = 1'b1; run(40);
    g_in[0] = 1'b0; run(1000);

    // Follow mode: short pulse swallowed, long pulse passed with rise/fall delays
    g_clr = '1; run(1); g_clr = '0;
    g_mode = 1'b1; g_rd = 16'd8; g_fd = 16'd4;
    g_in[1] = 1'b1; run(5);
    g_in[1] = 1'b0; run(15);
    g_in[1] = 1'b1; run(20);
    g_in[1] = 1'b0; run(10);

    // Follow mode: brief dip while high is absorbed by the fall delay
    g_in[2] = 1'b1; run(12);
    g_in[2] = 1'b0; run(2);
    g_in[2] = 1'b1; run(10);

    // Clear mid rise-count with input held high, then a fresh rise
    g_rd = 16'd10;
    g_in[3] = 1'b1; run(5);
    g_clr[3] = 1'b1; run(1); g_clr[3] = 1'b0;
    run(20);
    g_in[3] = 1'b0; run(1);
    g_in[3] = 1'b1; run(12);

    // Delay change during a running count
    g_clr = '1; g_in = '0; run(2); g_clr = '0;
    g_rd = 16'd100; g_in[0] = 1'b1; run(3);
    g_rd = 16'd5; run(110);

    // Mode dropped to LATCH during FALL_WAIT
    g_rd = 16'd0; g_fd = 16'd6; g_in[1] = 1'b0; run(1);
    g_in[1] = 1'b1; run(2);
    g_in[1] = 1'b0; run(2);
    g_mode = 1'b0; run(3);
    g_mode = 1'b1; run(3);

    // Reset mid-count on all lanes, zero rise delay afterwards
    g_clr = '1; g_in = '0; run(1); g_clr = '0;
    g_rd = 16'd50; g_in = 4'b1011; run(10);
    g_rst = 1'b0; run(2);
    g_rd = 16'd0; g_rst = 1'b1; run(4);

    // Random traffic
    g_clr = '1; g_in = '0; run(1); g_clr = '0;
    rst_hold = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int l = 0; l < LANES; l++) begin
        if ($urandom_range(0, 7) == 0) g_in[l] = ~g_in[l];
        g_clr[l] = ($urandom_range(0, 63) == 0);
      end
      if ($urandom_range(0, 199) == 0) g_mode = ~g_mode;
      if ($urandom_range(0, 19) == 0) g_rd = CNT_W'($urandom_range(0, 12));
      if ($urandom_range(0, 19) == 0) g_fd = CNT_W'($urandom_range(0, 12));
      if (rst_hold > 0) rst_hold--;
      else if ($urandom_range(0, 499) == 0) rst_hold = $urandom_range(1, 2);
      g_rst = (rst_hold == 0);
      step();
    end
    g_clr = '0; g_rst = 1'b1;
    run(20);

    @(posedge clk);
    #3;
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain actual=%0d entries required=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
